// File: rtl/float_divider.sv
// Iterative 24-bit float divider: one restoring quotient bit per clock.
// valid/ready on both sides; fixed 19-edge latency from accept to out_valid.
module float_divider #(
   parameter int EXP_W = 7,
   parameter int MAN_W = 16,
   parameter int BIAS  = 63
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   float_a,
   input  logic [EXP_W+MAN_W:0]   float_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   float_out,
   output logic                   float_out_overflow,
   output logic                   float_out_underflow,
   output logic                   float_out_div_by_zero,
   output logic [1:0]             state_dbg
);

   localparam int W       = 1 + EXP_W + MAN_W;
   localparam int DW      = MAN_W + 1;          // significand with hidden one
   localparam int QW      = MAN_W + 2;          // quotient / remainder width
   localparam int EW      = EXP_W + 3;          // signed working exponent
   localparam int CW      = $clog2(QW);
   localparam int EXP_MAX = (1 << EXP_W) - 1;

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_next;

   logic                 sign_r;
   logic                 zero_a_r;
   logic                 zero_b_r;
   logic signed [EW-1:0] exp_r;
   logic [DW-1:0]        div_r;
   logic                 a_lsb_r;
   logic [QW-1:0]        rem_r;
   logic [QW-1:0]        q_r;
   logic [CW-1:0]        cnt_r;

   logic                 accept;
   logic [QW-1:0]        trial;
   logic                 trial_ge;
   logic [QW-1:0]        trial_sub;
   logic signed [EW-1:0] exp_n;
   logic [MAN_W-1:0]     frac_n;
   logic                 exp_over;
   logic                 exp_under;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign state_dbg = state;
   assign accept    = in_valid && in_ready;

   // The remainder starts as the top MAN_W dividend bits; the first step
   // brings in the dividend LSB, every later step brings in a zero.
   always_comb begin
      trial     = {rem_r[QW-2:0], (cnt_r == CW'(QW-1)) ? a_lsb_r : 1'b0};
      trial_ge  = (trial >= {1'b0, div_r});
      trial_sub = trial - {1'b0, div_r};
   end

   always_comb begin
      exp_n     = q_r[QW-1] ? exp_r : exp_r - EW'(1);
      frac_n    = q_r[QW-1] ? q_r[QW-2:1] : q_r[QW-3:0];
      exp_over  = !exp_n[EW-1] && (exp_n > $signed(EW'(EXP_MAX)));
      exp_under = exp_n[EW-1] || (exp_n == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = DIV;
         DIV:  if (cnt_r == '0) state_next = NORM;
         NORM: state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sign_r                <= 1'b0;
         zero_a_r              <= 1'b0;
         zero_b_r              <= 1'b0;
         exp_r                 <= '0;
         div_r                 <= '0;
         a_lsb_r               <= 1'b0;
         rem_r                 <= '0;
         q_r                   <= '0;
         cnt_r                 <= '0;
         float_out             <= '0;
         float_out_overflow    <= 1'b0;
         float_out_underflow   <= 1'b0;
         float_out_div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               sign_r   <= float_a[W-1] ^ float_b[W-1];
               zero_a_r <= (float_a[W-2:MAN_W] == '0);
               zero_b_r <= (float_b[W-2:MAN_W] == '0);
               exp_r    <= EW'(float_a[W-2:MAN_W]) - EW'(float_b[W-2:MAN_W]) + EW'(BIAS);
               div_r    <= {1'b1, float_b[MAN_W-1:0]};
               a_lsb_r  <= float_a[0];
               rem_r    <= {2'b01, float_a[MAN_W-1:1]};
               q_r      <= '0;
               cnt_r    <= CW'(QW-1);
            end
            DIV: begin
               rem_r <= trial_ge ? trial_sub : trial;
               q_r   <= {q_r[QW-2:0], trial_ge};
               if (cnt_r != '0) cnt_r <= cnt_r - CW'(1);
            end
            NORM: begin
               float_out_overflow    <= 1'b0;
               float_out_underflow   <= 1'b0;
               float_out_div_by_zero <= 1'b0;
               if (zero_b_r) begin
                  float_out             <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                  float_out_overflow    <= 1'b1;
                  float_out_div_by_zero <= 1'b1;
               end else if (zero_a_r) begin
                  float_out <= '0;
               end else if (exp_over) begin
                  float_out          <= {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                  float_out_overflow <= 1'b1;
               end else if (exp_under) begin
                  float_out           <= '0;
                  float_out_underflow <= 1'b1;
               end else begin
                  float_out <= {sign_r, exp_n[EXP_W-1:0], frac_n};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_float_divider.sv
// Directed-vector bench for float_divider: table of hand-computed quotients
// plus backpressure and mid-division reset sequences.
module tb_float_divider;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] float_a;
   logic [23:0] float_b;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] float_out;
   logic        float_out_overflow;
   logic        float_out_underflow;
   logic        float_out_div_by_zero;
   logic [1:0]  state_dbg;

   int total = 0;
   int bad   = 0;

   // {float_out, overflow, underflow, div_by_zero}
   logic [26:0] exp_q[$];

   typedef struct {
      logic [23:0] a;
      logic [23:0] b;
      logic [26:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[8];

   float_divider dut (
      .clk                   (clk),
      .rst                   (rst),
      .in_valid              (in_valid),
      .in_ready              (in_ready),
      .float_a               (float_a),
      .float_b               (float_b),
      .out_valid             (out_valid),
      .out_ready             (out_ready),
      .float_out             (float_out),
      .float_out_overflow    (float_out_overflow),
      .float_out_underflow   (float_out_underflow),
      .float_out_div_by_zero (float_out_div_by_zero),
      .state_dbg             (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Offer operands at a negedge and hold until the accepting edge; returns #1 after it.
   task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic [26:0] exp);
      int guard;
      @(negedge clk);
      in_valid = 1'b1;
      float_a  = a;
      float_b  = b;
      guard    = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("accept_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      exp_q.push_back(exp);
   endtask

   // Count rising edges from the accept edge until out_valid, bounded.
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic check_result(input string name);
      logic [26:0] exp;
      exp = exp_q.pop_front();
      check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
      check({name, "_out"}, {5'b0, float_out, float_out_overflow, float_out_underflow,
                             float_out_div_by_zero}, {5'b0, exp});
   endtask

   task automatic take_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("handoff_valid", {31'b0, out_valid}, 32'd0);
      check("handoff_ready", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      issue(v.a, v.b, v.exp);
      wait_out(lat);
      check({v.name, "_latency"}, lat, 32'd19);
      check_result(v.name);
      take_result();
   endtask

   initial begin
      int          lat;
      int          spurious;
      logic [23:0] held;

      vecs[0] = '{24'h3F0000, 24'h3F0000, {24'h3F0000, 3'b000}, "one_by_one"};
      vecs[1] = '{24'h408000, 24'h400000, {24'h3F8000, 3'b000}, "three_by_two"};
      vecs[2] = '{24'hC18000, 24'h400000, {24'hC08000, 3'b000}, "neg6_by_2"};
      vecs[3] = '{24'h3F0000, 24'h3F8000, {24'h3E5555, 3'b000}, "one_by_1p5"};
      vecs[4] = '{24'h7F0000, 24'h010000, {24'h7FFFFF, 3'b100}, "overflow"};
      vecs[5] = '{24'h010000, 24'h7F0000, {24'h000000, 3'b010}, "underflow"};
      vecs[6] = '{24'hBF0000, 24'h000000, {24'hFFFFFF, 3'b101}, "div_zero"};
      vecs[7] = '{24'h000000, 24'h400000, {24'h000000, 3'b000}, "zero_num"};

      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      float_a   = '0;
      float_b   = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", {31'b0, in_ready}, 32'd1);
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_outputs", {5'b0, float_out, float_out_overflow, float_out_underflow,
                              float_out_div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Backpressure: result must stay put and new operands be ignored.
      issue(24'h408000, 24'h400000, {24'h3F8000, 3'b000});
      wait_out(lat);
      check("bp_latency", lat, 32'd19);
      held = float_out;
      @(negedge clk);
      in_valid = 1'b1;
      float_a  = 24'h3F0000;
      float_b  = 24'h3F8000;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold_out", {8'b0, float_out}, {8'b0, held});
         check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
         check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      end
      check_result("bp");
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_release_ready", {31'b0, in_ready}, 32'd1);
      check("bp_release_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_next_accepted", {31'b0, in_ready}, 32'd0);
      exp_q.push_back({24'h3E5555, 3'b000});
      wait_out(lat);
      check("bp_next_latency", lat, 32'd19);
      check_result("bp_next");
      take_result();

      // Reset during the 7th division cycle abandons the operation.
      issue(24'h3F0000, 24'h3F0000, {24'h3F0000, 3'b000});
      void'(exp_q.pop_back());
      repeat (6) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
      check("rst_mid_outputs", {5'b0, float_out, float_out_overflow, float_out_underflow,
                                float_out_div_by_zero}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      spurious = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) spurious++;
      end
      check("rst_no_spurious", spurious, 32'd0);
      check("rst_idle_ready", {31'b0, in_ready}, 32'd1);
      run_vec(vecs[0]);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
